// File: rtl/vs_spi_sequencer_if.sv
// ---------------------------------------------------------------------------
// vs_spi_sequencer_if
// Bundles the command port, the data-byte source port, the byte-engine port
// and the chip selects of the VS SPI sequencer.
//   master : the sequencer itself (drives acks, pops, spi_go/spi_tx, selects)
//   slave  : the environment (command issuer, data source, byte engine)
// ---------------------------------------------------------------------------
interface vs_spi_sequencer_if;
    logic        cmd_req;
    logic        cmd_rw;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_ack;
    logic [15:0] cmd_rdata;
    logic        dat_valid;
    logic [7:0]  dat_byte;
    logic        dat_ready;
    logic        dreq;
    logic        spi_go;
    logic [7:0]  spi_tx;
    logic [7:0]  spi_rx;
    logic        spi_done;
    logic        xcs;
    logic        xdcs;
    logic        busy;

    modport master (
        input  cmd_req, cmd_rw, cmd_addr, cmd_wdata, dat_valid, dat_byte,
               dreq, spi_rx, spi_done,
        output cmd_ack, cmd_rdata, dat_ready, spi_go, spi_tx, xcs, xdcs, busy
    );

    modport slave (
        output cmd_req, cmd_rw, cmd_addr, cmd_wdata, dat_valid, dat_byte,
               dreq, spi_rx, spi_done,
        input  cmd_ack, cmd_rdata, dat_ready, spi_go, spi_tx, xcs, xdcs, busy
    );
endinterface

// File: rtl/vs_spi_sequencer.sv
// ---------------------------------------------------------------------------
// vs_spi_sequencer
// Sequences register commands (4-byte SCI frames under xcs) and streamed data
// bursts (up to BURST_LEN bytes under xdcs) onto an external SPI byte engine.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : vs_spi_sequencer_if.master (command, data source, byte engine,
//          chip selects, busy)
// ---------------------------------------------------------------------------
module vs_spi_sequencer #(
    parameter int BURST_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    vs_spi_sequencer_if.master    bus
);
    // counter must hold BURST_LEN and also index the four command bytes
    localparam int CW = ($clog2(BURST_LEN + 1) < 2) ? 2 : $clog2(BURST_LEN + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CMD_SETUP = 4'd1,
        CMD_BYTE  = 4'd2,
        CMD_WAIT  = 4'd3,
        CMD_END   = 4'd4,
        DAT_SETUP = 4'd5,
        DAT_BYTE  = 4'd6,
        DAT_WAIT  = 4'd7,
        DAT_END   = 4'd8,
        GAP       = 4'd9
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            last_cmd_q;
    logic            xcs_q;
    logic            xdcs_q;
    logic            spi_go_q;
    logic [7:0]      spi_tx_q;
    logic            dat_ready_q;
    logic            cmd_ack_q;
    logic [15:0]     cmd_rdata_q;
    logic            busy_q;
    logic [CW-1:0]   cnt_d;
    logic            burst_full_d;
    logic            pick_cmd_d;

    // Byte k of a command frame: opcode, address, then data (zeros on read)
    function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic rw,
                                            input logic [7:0] addr, input logic [15:0] wdata);
        logic [7:0] b;
        case (idx)
            2'd0:    b = rw ? 8'h03 : 8'h02;
            2'd1:    b = addr;
            2'd2:    b = rw ? 8'h00 : wdata[15:8];
            2'd3:    b = rw ? 8'h00 : wdata[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign cnt_d        = cnt_q + CW'(1);
    assign burst_full_d = (cnt_d == CW'(BURST_LEN));
    // a pending burst beats a command only right after a command (alternation)
    assign pick_cmd_d   = bus.cmd_req && !(last_cmd_q && bus.dat_valid);

    // Transaction FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_cmd_q  <= 1'b0;
            xcs_q       <= 1'b1;
            xdcs_q      <= 1'b1;
            spi_go_q    <= 1'b0;
            spi_tx_q    <= 8'h00;
            dat_ready_q <= 1'b0;
            cmd_ack_q   <= 1'b0;
            cmd_rdata_q <= 16'h0000;
            busy_q      <= 1'b0;
        end else begin
            spi_go_q    <= 1'b0;
            dat_ready_q <= 1'b0;
            cmd_ack_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.dreq && pick_cmd_d) begin
                        state_q    <= CMD_SETUP;
                        xcs_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        last_cmd_q <= 1'b1;
                    end else if (bus.dreq && bus.dat_valid) begin
                        state_q    <= DAT_SETUP;
                        xdcs_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        last_cmd_q <= 1'b0;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                CMD_SETUP: begin
                    cnt_q    <= '0;
                    state_q  <= CMD_BYTE;
                    spi_go_q <= 1'b1;
                    spi_tx_q <= cmd_byte(2'd0, bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata);
                end
                CMD_BYTE: state_q <= CMD_WAIT;
                CMD_WAIT: begin
                    if (bus.spi_done) begin
                        if (bus.cmd_rw && cnt_q == CW'(2)) cmd_rdata_q[15:8] <= bus.spi_rx;
                        if (bus.cmd_rw && cnt_q == CW'(3)) cmd_rdata_q[7:0]  <= bus.spi_rx;
                        if (cnt_q == CW'(3)) begin
                            state_q   <= CMD_END;
                            xcs_q     <= 1'b1;
                            cmd_ack_q <= 1'b1;
                        end else begin
                            cnt_q    <= cnt_d;
                            state_q  <= CMD_BYTE;
                            spi_go_q <= 1'b1;
                            spi_tx_q <= cmd_byte(cnt_d[1:0], bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata);
                        end
                    end
                end
                CMD_END: state_q <= GAP;
                DAT_SETUP: begin
                    cnt_q <= '0;
                    if (bus.dat_valid) begin
                        state_q     <= DAT_BYTE;
                        spi_go_q    <= 1'b1;
                        dat_ready_q <= 1'b1;
                        spi_tx_q    <= bus.dat_byte;
                    end else begin
                        state_q <= DAT_END;
                        xdcs_q  <= 1'b1;
                    end
                end
                DAT_BYTE: state_q <= DAT_WAIT;
                DAT_WAIT: begin
                    // dreq is deliberately ignored here: a burst is never cut by it
                    if (bus.spi_done) begin
                        cnt_q <= cnt_d;
                        if (burst_full_d || !bus.dat_valid) begin
                            state_q <= DAT_END;
                            xdcs_q  <= 1'b1;
                        end else begin
                            state_q     <= DAT_BYTE;
                            spi_go_q    <= 1'b1;
                            dat_ready_q <= 1'b1;
                            spi_tx_q    <= bus.dat_byte;
                        end
                    end
                end
                DAT_END: state_q <= GAP;
                GAP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    xcs_q   <= 1'b1;
                    xdcs_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.xcs       = xcs_q;
    assign bus.xdcs      = xdcs_q;
    assign bus.spi_go    = spi_go_q;
    assign bus.spi_tx    = spi_tx_q;
    assign bus.dat_ready = dat_ready_q;
    assign bus.cmd_ack   = cmd_ack_q;
    assign bus.cmd_rdata = cmd_rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_vs_spi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vs_spi_sequencer
// Randomized bench for vs_spi_sequencer (BURST_LEN=32). A byte-engine model
// answers spi_go with spi_done after a random latency, a FIFO model feeds the
// data port, and a monitor reduces the bus to transactions (command bytes,
// data stream, burst lengths, gaps, order) that are compared with
// expectations derived from the frame and burst rules.
// ---------------------------------------------------------------------------
module tb_vs_spi_sequencer;
    localparam int BL = 32;

    logic clk;
    logic rst;
    vs_spi_sequencer_if bus();

    vs_spi_sequencer #(.BURST_LEN(BL)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int n_tests = 0;
    int n_fail  = 0;

    // monitor-owned observations
    int         go_cnt = 0, ack_cnt = 0, both_low = 0, setup_err = 0, ack_err = 0, dr_err = 0;
    logic [7:0] cmd_tx[$];
    logic [7:0] dat_tx[$];
    int         burst_len_q[$];
    int         gap_q[$];
    bit         order_q[$];   // 1 = command, 0 = data burst

    // main-owned stimulus state
    logic [7:0]  rx_plan[4];
    logic [7:0]  src_mem[$];
    logic [15:0] exp_rdata;

    // fifo-owned read pointer
    int rd_ptr = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // byte engine: spi_done 1..3 cycles after spi_go; command bytes answer from rx_plan
    initial begin
        int wait_n = 0, k = 0;
        logic prev_xcs = 1'b1;
        bus.spi_done = 1'b0;
        bus.spi_rx   = 8'h00;
        forever begin
            @(negedge clk);
            bus.spi_done = 1'b0;
            if (prev_xcs && !bus.xcs) k = 0;
            prev_xcs = bus.xcs;
            if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0) bus.spi_done = 1'b1;
            end
            if (bus.spi_go) begin
                wait_n = $urandom_range(1, 3);
                if (!bus.xcs) begin
                    bus.spi_rx = rx_plan[k % 4];
                    k++;
                end else begin
                    bus.spi_rx = 8'($urandom);
                end
            end
        end
    end

    // data source: head of src_mem, popped at the clock edge that ends a dat_ready cycle
    initial begin
        bit pop;
        bus.dat_valid = 1'b0;
        bus.dat_byte  = 8'h00;
        forever begin
            @(negedge clk);
            pop = bus.dat_ready;
            @(posedge clk);
            #1;
            if (pop) rd_ptr++;
            bus.dat_valid = (rd_ptr < src_mem.size());
            bus.dat_byte  = (rd_ptr < src_mem.size()) ? src_mem[rd_ptr] : 8'h00;
        end
    end

    // monitor: reduce the bus to transactions
    initial begin
        logic prev_xcs = 1'b1, prev_xdcs = 1'b1;
        bit   pending = 0;
        int   setup_cyc = 0, cur_burst = 0, high_run = 0;
        forever begin
            @(negedge clk);
            if (!bus.xcs && !bus.xdcs) both_low++;
            if (prev_xcs && !bus.xcs) begin
                order_q.push_back(1'b1);
                pending = 1; setup_cyc = 1;
            end else if (prev_xdcs && !bus.xdcs) begin
                order_q.push_back(1'b0);
                gap_q.push_back(high_run);
                pending = 1; setup_cyc = 1; cur_burst = 0;
            end else if (pending && !bus.spi_go) begin
                setup_cyc++;
            end
            if (bus.spi_go) begin
                go_cnt++;
                if (pending && setup_cyc != 1) setup_err++;
                pending = 0;
                if (!bus.xcs) cmd_tx.push_back(bus.spi_tx);
                if (!bus.xdcs) begin
                    dat_tx.push_back(bus.spi_tx);
                    cur_burst++;
                    if (!bus.dat_ready) dr_err++;
                end
            end
            if (bus.dat_ready && !(bus.spi_go && !bus.xdcs)) dr_err++;
            if (!prev_xdcs && bus.xdcs) begin
                burst_len_q.push_back(cur_burst);
                high_run = 1;
            end else if (bus.xdcs) begin
                high_run++;
            end
            if (bus.cmd_ack) begin
                ack_cnt++;
                if (!(bus.xcs && !prev_xcs)) ack_err++;
            end
            prev_xcs  = bus.xcs;
            prev_xdcs = bus.xdcs;
        end
    end

    // issue one command; optionally hold dreq low for hold cycles first
    task automatic run_cmd(input string tag, input logic rw, input logic [7:0] addr,
                           input logic [15:0] wd, input logic [31:0] rx,
                           input int hold, input int exp_dat);
        int cbase, abase, dbase, gbase;
        bit ok;
        logic [31:0] got, exp_tx;
        rx_plan[0] = rx[31:24]; rx_plan[1] = rx[23:16];
        rx_plan[2] = rx[15:8];  rx_plan[3] = rx[7:0];
        cbase = cmd_tx.size(); abase = ack_cnt; dbase = dat_tx.size(); gbase = go_cnt;
        bus.cmd_rw = rw; bus.cmd_addr = addr; bus.cmd_wdata = wd; bus.cmd_req = 1'b1;
        if (hold > 0) begin
            repeat (hold) tick();
            check_eq({tag, "_no_go_dreq0"}, go_cnt - gbase, 0);
            bus.dreq = 1'b1;
        end
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (ack_cnt != abase) begin ok = 1; break; end
        end
        bus.cmd_req = 1'b0;
        if (!ok) check_eq({tag, "_ack_timeout"}, 0, 1);
        repeat (4) tick();
        exp_tx = rw ? {8'h03, addr, 16'h0000} : {8'h02, addr, wd};
        if (rw) exp_rdata = rx[15:0];
        got = 32'h0;
        for (int i = 0; i < 4; i++)
            got = {got[23:0], (cbase + i < cmd_tx.size()) ? cmd_tx[cbase + i] : 8'h00};
        check_eq({tag, "_tx"}, got, exp_tx);
        check_eq({tag, "_nbytes"}, cmd_tx.size() - cbase, 4);
        check_eq({tag, "_acks"}, ack_cnt - abase, 1);
        check_eq({tag, "_rdata"}, bus.cmd_rdata, exp_rdata);
        check_eq({tag, "_dat_bytes"}, dat_tx.size() - dbase, exp_dat);
    endtask

    // stream n bytes; optionally drop dreq once drop_at bytes have gone out
    task automatic run_data(input string tag, input int n, input int drop_at);
        int sbase, dbase, bbase, gbase, mism, nb, rem;
        bit ok;
        sbase = src_mem.size(); dbase = dat_tx.size();
        bbase = burst_len_q.size(); gbase = gap_q.size();
        for (int i = 0; i < n; i++) src_mem.push_back(8'($urandom));
        if (drop_at > 0) begin
            ok = 0;
            for (int i = 0; i < 1000; i++) begin
                tick();
                if (dat_tx.size() >= dbase + drop_at) begin ok = 1; break; end
            end
            if (!ok) check_eq({tag, "_drop_timeout"}, 0, 1);
            bus.dreq = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (rd_ptr == src_mem.size() && !bus.busy) begin ok = 1; break; end
        end
        if (!ok) check_eq({tag, "_drain_timeout"}, 0, 1);
        repeat (2) tick();
        bus.dreq = 1'b1;
        mism = 0;
        for (int i = 0; i < n; i++)
            if (dbase + i >= dat_tx.size() || dat_tx[dbase + i] !== src_mem[sbase + i]) mism++;
        check_eq({tag, "_stream_mism"}, mism, 0);
        check_eq({tag, "_nbytes"}, dat_tx.size() - dbase, n);
        nb = (n + BL - 1) / BL;
        check_eq({tag, "_nbursts"}, burst_len_q.size() - bbase, nb);
        rem = n;
        for (int j = 0; j < nb && bbase + j < burst_len_q.size(); j++) begin
            check_eq($sformatf("%s_burst%0d_len", tag, j), burst_len_q[bbase + j],
                     (rem > BL) ? BL : rem);
            rem -= BL;
            if (j > 0 && gbase + j < gap_q.size())
                check_eq($sformatf("%s_gap%0d", tag, j), gap_q[gbase + j], 3);
        end
    endtask

    initial begin
        int abase, obase;
        bus.cmd_req = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = 8'h00;
        bus.cmd_wdata = 16'h0000; bus.dreq = 1'b0;
        rx_plan[0] = 8'h00; rx_plan[1] = 8'h00; rx_plan[2] = 8'h00; rx_plan[3] = 8'h00;
        exp_rdata = 16'h0000;
        rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_xcs", bus.xcs, 1);
        check_eq("rst_xdcs", bus.xdcs, 1);
        check_eq("rst_spi_go", bus.spi_go, 0);
        check_eq("rst_spi_tx", bus.spi_tx, 0);
        check_eq("rst_dat_ready", bus.dat_ready, 0);
        check_eq("rst_cmd_ack", bus.cmd_ack, 0);
        check_eq("rst_cmd_rdata", bus.cmd_rdata, 0);
        check_eq("rst_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (2) tick();
        bus.dreq = 1'b1;

        run_cmd("wr_0b", 1'b0, 8'h0B, 16'h2020, 32'h11223344, 0, 0);
        run_cmd("rd_01", 1'b1, 8'h01, 16'h5555, 32'h0000ABCD, 0, 0);
        for (int i = 0; i < 8; i++)
            run_cmd($sformatf("rnd_cmd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom),
                    16'($urandom), $urandom, 0, 0);

        run_data("burst40", 40, 0);
        run_data("short5", 5, 0);
        run_data("dreq_drop", 12, 3);
        for (int i = 0; i < 3; i++)
            run_data($sformatf("rnd_dat%0d", i), $urandom_range(1, 70), 0);

        // alternation: after a command, a pending burst goes before the next command
        run_cmd("alt_pre", 1'b0, 8'h22, 16'hBEEF, 32'h0, 0, 0);
        bus.dreq = 1'b0;
        obase = order_q.size();
        for (int i = 0; i < 4; i++) src_mem.push_back(8'($urandom));
        run_cmd("alt_cmd", 1'b0, 8'h33, 16'hC0DE, 32'h0, 20, 4);
        check_eq("alt_order_n", order_q.size() - obase, 2);
        if (order_q.size() >= obase + 2)
            check_eq("alt_order", {order_q[obase], order_q[obase + 1]}, 2'b01);

        // reset during byte 2 of a command
        abase = ack_cnt;
        rx_plan[0] = 8'h00; rx_plan[1] = 8'h00; rx_plan[2] = 8'h00; rx_plan[3] = 8'h00;
        bus.cmd_rw = 1'b0; bus.cmd_addr = 8'h44; bus.cmd_wdata = 16'h1234; bus.cmd_req = 1'b1;
        obase = cmd_tx.size();
        for (int i = 0; i < 200 && cmd_tx.size() < obase + 2; i++) tick();
        check_eq("rstmid_reached_byte2", cmd_tx.size() - obase, 2);
        check_eq("rstmid_xcs_before", bus.xcs, 0);
        rst = 1'b1;
        #1;
        check_eq("rstmid_xcs_async", bus.xcs, 1);
        check_eq("rstmid_busy", bus.busy, 0);
        repeat (2) tick();
        bus.cmd_req = 1'b0;
        rst = 1'b0;
        exp_rdata = 16'h0000;
        repeat (10) tick();
        check_eq("rstmid_no_ack", ack_cnt - abase, 0);
        run_cmd("post_rst", 1'b1, 8'h55, 16'h0000, 32'h9988C33C, 0, 0);

        check_eq("never_both_cs_low", both_low, 0);
        check_eq("setup_one_cycle", setup_err, 0);
        check_eq("ack_at_xcs_rise", ack_err, 0);
        check_eq("dat_ready_with_go", dr_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vs_spi_sequencer.md
VS_SPI_SEQUENCER -- requirements
Module: vs_spi_sequencer

Interface
REQ-001 Parameter: BURST_LEN, default 32, number of data bytes sent per data burst while dreq is high.
REQ-002 clk  input  1  system clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_req  input  1  command request; held high until cmd_ack.
REQ-005 cmd_rw  input  1  1 = register read, 0 = register write; stable while cmd_req high.
REQ-006 cmd_addr  input  8  register address; stable while cmd_req high.
REQ-007 cmd_wdata  input  16  register write data; stable while cmd_req high.
REQ-008 cmd_ack  output  1  one-cycle pulse when the command transaction completes.
REQ-009 cmd_rdata  output  16  read result; valid from cmd_ack until the next cmd_ack.
REQ-010 dat_valid  input  1  data byte available.
REQ-011 dat_byte  input  8  data byte to stream.
REQ-012 dat_ready  output  1  one-cycle pop pulse; dat_byte consumed this cycle.
REQ-013 dreq  input  1  codec ready-for-transfer flag, synchronous to clk.
REQ-014 spi_go  output  1  one-cycle start pulse to the byte engine.
REQ-015 spi_tx  output  8  byte to transmit; valid in the spi_go cycle.
REQ-016 spi_rx  input  8  received byte; valid in the spi_done cycle.
REQ-017 spi_done  input  1  one-cycle byte-complete pulse from the byte engine.
REQ-018 xcs  output  1  command chip select, active-low.
REQ-019 xdcs  output  1  data chip select, active-low.
REQ-020 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-021 States SHALL be IDLE, CMD_SETUP, CMD_BYTE, CMD_WAIT, CMD_END, DAT_SETUP, DAT_BYTE, DAT_WAIT, DAT_END, GAP.
REQ-022 The FSM SHALL start a transaction from IDLE only when dreq=1; with dreq=0 it remains in IDLE regardless of requests.
REQ-023 Arbitration in IDLE: cmd_req wins over dat_valid, except that when the previous transaction was a command and dat_valid=1, the data burst SHALL win (alternation, no starvation).
REQ-024 Setup states SHALL drive the selected chip select low for exactly one cycle before the first spi_go.
REQ-025 A command transaction SHALL send 4 bytes: 0x03 (read) or 0x02 (write); cmd_addr; cmd_wdata[15:8] or 0x00 (read); cmd_wdata[7:0] or 0x00 (read).
REQ-026 On a read, spi_rx at spi_done of byte 3 SHALL load cmd_rdata[15:8], and spi_rx at spi_done of byte 4 SHALL load cmd_rdata[7:0]; cmd_rdata SHALL be unchanged on a write.
REQ-027 In the BYTE states, spi_go SHALL pulse for one cycle with spi_tx valid; the WAIT states SHALL hold until spi_done; the next spi_go SHALL occur in the cycle after spi_done.
REQ-028 A data burst SHALL send up to BURST_LEN bytes; dat_ready SHALL pulse in the same cycle as each data spi_go, with spi_tx = dat_byte.
REQ-029 A burst SHALL end early at a byte boundary when dat_valid=0; dreq falling mid-burst SHALL NOT abort the burst.
REQ-030 END states SHALL deassert the chip select; cmd_ack SHALL pulse in the first cycle in which xcs is high again.
REQ-031 GAP SHALL last one cycle with xcs=xdcs=1 before IDLE; xcs and xdcs SHALL never be low simultaneously.
REQ-032 A spi_done outside the WAIT states SHALL be ignored.
REQ-033 The byte counter SHALL be wide enough for BURST_LEN and SHALL reset to 0 at each setup state.

Reset
REQ-034 During rst=1: state IDLE, xcs=1, xdcs=1, spi_go=0, spi_tx=0x00, dat_ready=0, cmd_ack=0, cmd_rdata=0x0000, busy=0, counter=0, alternation flag cleared.
REQ-035 Reset asserted mid-transaction SHALL release both chip selects immediately (asynchronously) and SHALL abandon the transaction without issuing cmd_ack.

Verification
REQ-036 Write cmd_addr=0x0B, cmd_wdata=0x2020, dreq=1 -> xcs low, tx 02 0B 20 20, xcs high, one cmd_ack, xdcs stays 1.
REQ-037 Read cmd_addr=0x01, engine model returns rx 00 00 AB CD -> tx 03 01 00 00, cmd_rdata=0xABCD at cmd_ack.
REQ-038 dat_valid held 1, dreq=1, BURST_LEN=32 -> 32 spi_go pulses, 32 dat_ready pulses, xdcs low throughout, one GAP cycle, then a new burst.
REQ-039 cmd_req and dat_valid both high after a command completes -> data burst served before the next command; dreq=0 -> no spi_go.
REQ-040 dat_valid drops after 5 bytes -> burst ends after byte 5; dreq drops mid-burst -> burst continues.
REQ-041 rst pulse during byte 2 of a command -> xcs=1 immediately, no cmd_ack, clean transaction after release.
